axis_multi_bram_loader: RTL and testbench
=========================================

AXIS_MULTI_BRAM_LOADER -- requirements
Module: axis_multi_bram_loader

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 3, the number of target BRAMs (matrix A, matrix B, instruction).
REQ-002 SHALL have parameter ADDR_W, default 11, the BRAM word-address width.
REQ-003 SHALL have parameter DATA_W, default 32, the stream and BRAM data width.
REQ-004 SHALL have parameter LANES, default 4, the row-padding granularity in words; it must be a power of 2.
REQ-005 S_AXIS_ACLK  in  1  sole clock; all logic is rising-edge.
REQ-006 S_AXIS_ARESET  in  1  reset; one clock; reset is synchronous and active-high.
REQ-007 S_AXIS_TDATA  in  DATA_W  stream payload.
REQ-008 S_AXIS_TVALID  in  1  payload valid.
REQ-009 S_AXIS_TREADY  out  1  loader accepts a beat.
REQ-010 S_AXIS_TLAST  in  1  last beat of the transfer.
REQ-011 cfg_start  in  1  one-cycle pulse that latches all cfg_* inputs and begins a load.
REQ-012 cfg_bank  in  BANK_W  target bank index; BANK_W = max(1, clog2(NUM_BANKS)).
REQ-013 cfg_row_width  in  16  valid words per row.
REQ-014 cfg_num_rows  in  16  rows in the transfer.
REQ-015 cfg_pad_mask  in  NUM_BANKS  per-bank enable for zero padding.
REQ-016 bram_addr  out  ADDR_W  write address, shared by all banks.
REQ-017 bram_din  out  DATA_W  write data, shared by all banks.
REQ-018 bram_we  out  NUM_BANKS  one-hot write enable.
REQ-019 busy  out  1  high outside IDLE.
REQ-020 done  out  1  one-cycle completion pulse.
REQ-021 err  out  3  sticky flags {ovf, long, short}, cleared by an accepted cfg_start.

Function
REQ-022 States SHALL be IDLE, STREAM, PAD, DRAIN, and DONE.
REQ-023 IDLE: TREADY=0. An accepted cfg_start latches the configuration and goes to STREAM. cfg_start outside IDLE is ignored.
REQ-024 Zero configuration: if cfg_start has cfg_row_width=0 or cfg_num_rows=0, the FSM SHALL go directly to DONE with no writes and no error flags set.
REQ-025 Padded width PW = cfg_row_width rounded up to a multiple of LANES when cfg_pad_mask[cfg_bank]=1; otherwise PW = cfg_row_width.
REQ-026 STREAM: TREADY=1. Each beat where TVALID&TREADY is high writes TDATA to address row*PW+col.
REQ-027 Write timing: bram_we, bram_addr and bram_din SHALL be registered, one cycle after the handshake. bram_we is asserted only on bit cfg_bank.
REQ-028 End of row in STREAM (col reaches cfg_row_width-1 on a handshake):
- if PW > cfg_row_width, go to PAD;
- else, if more rows remain, go to the next row;
- else, on the last row, go to DONE.
REQ-029 PAD: TREADY=0. Writes zero once per cycle for PW-cfg_row_width cycles, incrementing the address. Then goes to the next row, or to DONE after the last row.
REQ-030 Early TLAST (TLAST on a handshake before the last beat of the last row): set err[0]; pad the current row's remainder (up to PW) with zeros, then go to DONE. Remaining rows are not written.
REQ-031 Missing TLAST (last counted beat without TLAST): set err[1]; go to DRAIN. DRAIN: TREADY=1, beats are discarded with no writes, until a TLAST handshake, then go to DONE.
REQ-032 Address overflow: any write whose computed address exceeds 2^ADDR_W-1 SHALL be suppressed (no we) and SHALL set err[2]. Counting continues.
REQ-033 DONE: done=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-034 busy SHALL be 1 in every state except IDLE.
REQ-035 Row and column counters SHALL be 16 bits. The address is computed at ADDR_W+16 bits before the overflow compare.

Reset
REQ-036 While reset is high, the FSM SHALL go to IDLE and all outputs SHALL be 0: TREADY, bram_we, bram_addr, bram_din, busy, done and err.
REQ-037 Reset mid-load SHALL abort the load with no done pulse and no further writes.

Structure
REQ-038 The shared package fetch_pkg SHALL hold the state enum, the err bit indices (SHORT=0, LONG=1, OVF=2) and the LANES default.
REQ-039 Row/column/address counting and PW computation SHALL live in the sub-module loader_addr_gen. The FSM and output registers SHALL live in the top module.

Verification
REQ-040 Padded row: bank 0, row_width=5, rows=2, pad_mask[0]=1, 10 beats, TLAST on the 10th -> writes at addr 0-4 data, 5-7 zero, 8-12 data, 13-15 zero; done pulse; err=0.
REQ-041 Unpadded bank: bank 1, row_width=6, rows=1, pad_mask[1]=0 -> 6 writes on bram_we=3'b010; TREADY never drops mid-row.
REQ-042 Early TLAST: row_width=4, rows=3, TLAST on beat 6 -> addr 0-5 data, 6-7 zero; err=3'b001; done pulse.
REQ-043 Missing TLAST: row_width=4, rows=1, then 3 extra beats with TLAST on the last -> 4 writes only; err=3'b010; done after the extra TLAST.
REQ-044 Overflow: ADDR_W=4, row_width=8, rows=3 -> 16 writes only; err[2]=1; done pulse.
REQ-045 Mid-load reset: assert reset for 1 cycle after beat 3 -> outputs 0, no done; a new cfg_start then loads normally.

Source files
------------

// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared FSM states, error-bit indices and sizing constants.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STREAM = 3'd1,
    ST_PAD    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int ERR_SHORT     = 0;
  localparam int ERR_LONG      = 1;
  localparam int ERR_OVF       = 2;
  localparam int LANES_DEFAULT = 4;
  localparam int CNT_W         = 16;

endpackage

`default_nettype wire

// File: rtl/loader_addr_gen.sv
// ============================================================================
// Module      : loader_addr_gen
// Description : Row/column counters, padded width and overflow-aware address.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module loader_addr_gen
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int LANES  = LANES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [CNT_W-1:0]  row_width,
  input  logic [CNT_W-1:0]  num_rows,
  input  logic              pad_en,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_ovf,
  output logic              last_col,
  output logic              pad_end,
  output logic              last_row,
  output logic              need_pad
);

  localparam int C_PW_W = CNT_W + 1;
  localparam int C_AW   = ADDR_W + CNT_W;
  localparam logic [C_PW_W-1:0] C_LANE_MASK = C_PW_W'(LANES - 1);

  logic [CNT_W-1:0]  r_row_width;
  logic [CNT_W-1:0]  r_num_rows;
  logic [C_PW_W-1:0] r_pw;
  logic [CNT_W-1:0]  r_col;
  logic [CNT_W-1:0]  r_row;
  logic [C_AW-1:0]   r_addr;

  logic [C_PW_W-1:0] w_width_ext;
  logic [C_PW_W-1:0] w_pw;

  assign w_width_ext = {1'b0, row_width};
  assign w_pw = pad_en ? ((w_width_ext + C_LANE_MASK) & ~C_LANE_MASK) : w_width_ext;

  // A running address equals row*PW+col because every position of a row is visited in order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_width <= '0;
      r_num_rows  <= '0;
      r_pw        <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_addr      <= '0;
    end else if (load) begin
      r_row_width <= row_width;
      r_num_rows  <= num_rows;
      r_pw        <= w_pw;
      r_col       <= '0;
      r_row       <= '0;
      r_addr      <= '0;
    end else if (step) begin
      if ({1'b0, r_col} == r_pw - C_PW_W'(1)) begin
        r_col <= '0;
        r_row <= r_row + CNT_W'(1);
      end else begin
        r_col <= r_col + CNT_W'(1);
      end
      r_addr <= (&r_addr) ? r_addr : r_addr + C_AW'(1);
    end
  end

  assign addr     = r_addr[ADDR_W-1:0];
  assign addr_ovf = |r_addr[C_AW-1:ADDR_W];
  assign last_col = (r_col == r_row_width - CNT_W'(1));
  assign pad_end  = ({1'b0, r_col} == r_pw - C_PW_W'(1));
  assign last_row = (r_row == r_num_rows - CNT_W'(1));
  assign need_pad = (r_pw > {1'b0, r_row_width});

endmodule

`default_nettype wire

// File: rtl/axis_multi_bram_loader.sv
// ============================================================================
// Module      : axis_multi_bram_loader
// Description : AXI-Stream to multi-bank BRAM loader with per-row zero padding.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module axis_multi_bram_loader
  import fetch_pkg::*;
#(
  parameter int NUM_BANKS = 3,
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 32,
  parameter int LANES     = LANES_DEFAULT,
  localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 S_AXIS_ACLK,
  input  logic                 S_AXIS_ARESET,
  input  logic [DATA_W-1:0]    S_AXIS_TDATA,
  input  logic                 S_AXIS_TVALID,
  output logic                 S_AXIS_TREADY,
  input  logic                 S_AXIS_TLAST,
  input  logic                 cfg_start,
  input  logic [BANK_W-1:0]    cfg_bank,
  input  logic [15:0]          cfg_row_width,
  input  logic [15:0]          cfg_num_rows,
  input  logic [NUM_BANKS-1:0] cfg_pad_mask,
  output logic [ADDR_W-1:0]    bram_addr,
  output logic [DATA_W-1:0]    bram_din,
  output logic [NUM_BANKS-1:0] bram_we,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           err
);

  state_t               r_state;
  logic                 r_finish;
  logic                 r_drain;
  logic [NUM_BANKS-1:0] r_onehot;
  logic [NUM_BANKS-1:0] r_we;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_din;
  logic [2:0]           r_err;

  logic [NUM_BANKS-1:0] w_cfg_onehot;
  logic                 w_tready;
  logic                 w_hs;
  logic                 w_load;
  logic                 w_step;
  logic [ADDR_W-1:0]    w_addr;
  logic                 w_ovf;
  logic                 w_last_col;
  logic                 w_pad_end;
  logic                 w_last_row;
  logic                 w_need_pad;

  // An out-of-range bank index yields an all-zero one-hot: no writes, no padding.
  assign w_cfg_onehot = NUM_BANKS'(1) << cfg_bank;
  assign w_tready     = (r_state == ST_STREAM) || (r_state == ST_DRAIN);
  assign w_hs         = S_AXIS_TVALID && w_tready;
  assign w_load       = (r_state == ST_IDLE) && cfg_start;
  assign w_step       = ((r_state == ST_STREAM) && w_hs) || (r_state == ST_PAD);

  loader_addr_gen #(
    .ADDR_W (ADDR_W),
    .LANES  (LANES)
  ) u_addr_gen (
    .clk       (S_AXIS_ACLK),
    .rst       (S_AXIS_ARESET),
    .load      (w_load),
    .step      (w_step),
    .row_width (cfg_row_width),
    .num_rows  (cfg_num_rows),
    .pad_en    (|(cfg_pad_mask & w_cfg_onehot)),
    .addr      (w_addr),
    .addr_ovf  (w_ovf),
    .last_col  (w_last_col),
    .pad_end   (w_pad_end),
    .last_row  (w_last_row),
    .need_pad  (w_need_pad)
  );

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      r_state  <= ST_IDLE;
      r_finish <= 1'b0;
      r_drain  <= 1'b0;
      r_onehot <= '0;
      r_we     <= '0;
      r_addr   <= '0;
      r_din    <= '0;
      r_err    <= '0;
    end else begin
      r_we <= '0;
      case (r_state)
        ST_IDLE: begin
          if (cfg_start) begin
            r_err    <= '0;
            r_onehot <= w_cfg_onehot;
            r_finish <= 1'b0;
            r_drain  <= 1'b0;
            if ((cfg_row_width == 16'd0) || (cfg_num_rows == 16'd0)) r_state <= ST_DONE;
            else                                                     r_state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_hs) begin
            r_we   <= w_ovf ? '0 : r_onehot;
            r_addr <= w_addr;
            r_din  <= S_AXIS_TDATA;
            if (w_ovf) r_err[ERR_OVF] <= 1'b1;
            if (S_AXIS_TLAST && !(w_last_col && w_last_row)) begin
              r_err[ERR_SHORT] <= 1'b1;
              if (w_pad_end) begin
                r_state <= ST_DONE;
              end else begin
                r_finish <= 1'b1;
                r_state  <= ST_PAD;
              end
            end else if (w_last_col) begin
              if (w_last_row) begin
                // A missing TLAST still pads the final row before draining.
                if (!S_AXIS_TLAST) r_err[ERR_LONG] <= 1'b1;
                r_drain <= !S_AXIS_TLAST;
                if (w_need_pad) begin
                  r_finish <= 1'b1;
                  r_state  <= ST_PAD;
                end else begin
                  r_state <= S_AXIS_TLAST ? ST_DONE : ST_DRAIN;
                end
              end else if (w_need_pad) begin
                r_state <= ST_PAD;
              end
            end
          end
        end
        ST_PAD: begin
          r_we   <= w_ovf ? '0 : r_onehot;
          r_addr <= w_addr;
          r_din  <= '0;
          if (w_ovf) r_err[ERR_OVF] <= 1'b1;
          if (w_pad_end) begin
            if (r_finish) r_state <= r_drain ? ST_DRAIN : ST_DONE;
            else          r_state <= ST_STREAM;
          end
        end
        ST_DRAIN: begin
          if (w_hs && S_AXIS_TLAST) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign S_AXIS_TREADY = w_tready;
  assign bram_we       = r_we;
  assign bram_addr     = r_addr;
  assign bram_din      = r_din;
  assign busy          = (r_state != ST_IDLE);
  assign done          = (r_state == ST_DONE);
  assign err           = r_err;

endmodule

`default_nettype wire

// File: tb/tb_axis_multi_bram_loader.sv
// ============================================================================
// Module      : tb_axis_multi_bram_loader
// Description : Directed and random loads on two loaders (ADDR_W 11 and 4).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_axis_multi_bram_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        cfg_start;
  logic [1:0]  cfg_bank;
  logic [15:0] cfg_rw;
  logic [15:0] cfg_rows;
  logic [2:0]  cfg_mask;

  logic        tready0, tready4;
  logic [10:0] addr0;
  logic [3:0]  addr4;
  logic [31:0] din0, din4;
  logic [2:0]  we0, we4;
  logic        busy0, busy4, done0, done4;
  logic [2:0]  err0, err4;

  int vectors = 0;
  int miscompares = 0;
  int dn0 = 0;
  int dn4 = 0;
  logic [63:0] q0[$];
  logic [63:0] q4[$];
  logic [31:0] dat[$];
  int          exp_a[$];
  logic [31:0] exp_d[$];
  logic        exp_short, exp_long;

  always #5 clk = ~clk;

  axis_multi_bram_loader #(.NUM_BANKS(3), .ADDR_W(11), .DATA_W(32), .LANES(4)) u_dut0 (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .S_AXIS_TDATA(tdata), .S_AXIS_TVALID(tvalid),
    .S_AXIS_TREADY(tready0), .S_AXIS_TLAST(tlast), .cfg_start(cfg_start), .cfg_bank(cfg_bank),
    .cfg_row_width(cfg_rw), .cfg_num_rows(cfg_rows), .cfg_pad_mask(cfg_mask),
    .bram_addr(addr0), .bram_din(din0), .bram_we(we0), .busy(busy0), .done(done0), .err(err0));

  axis_multi_bram_loader #(.NUM_BANKS(3), .ADDR_W(4), .DATA_W(32), .LANES(4)) u_dut4 (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .S_AXIS_TDATA(tdata), .S_AXIS_TVALID(tvalid),
    .S_AXIS_TREADY(tready4), .S_AXIS_TLAST(tlast), .cfg_start(cfg_start), .cfg_bank(cfg_bank),
    .cfg_row_width(cfg_rw), .cfg_num_rows(cfg_rows), .cfg_pad_mask(cfg_mask),
    .bram_addr(addr4), .bram_din(din4), .bram_we(we4), .busy(busy4), .done(done4), .err(err4));

  function automatic logic [63:0] pk(input logic [2:0] we, input logic [15:0] a, input logic [31:0] d);
    return {13'd0, we, a, d};
  endfunction

  always @(negedge clk) begin
    if (we0 != 3'd0) q0.push_back(pk(we0, 16'(addr0), din0));
    if (we4 != 3'd0) q4.push_back(pk(we4, 16'(addr4), din4));
    if (done0) dn0++;
    if (done4) dn4++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected write stream: each reached row is laid out over PW slots, data then zeros.
  task automatic model(input int rw, input int rows, input bit pad, input int tl);
    int pw, total, ndata;
    pw    = pad ? ((rw + 3) / 4) * 4 : rw;
    total = rw * rows;
    ndata = (tl < total) ? tl : total;
    exp_a.delete();
    exp_d.delete();
    exp_short = 1'b0;
    exp_long  = 1'b0;
    if (rw == 0 || rows == 0) return;
    exp_short = (tl < total);
    exp_long  = (tl > total);
    for (int r = 0; r * rw < ndata; r++) begin
      for (int c = 0; c < pw; c++) begin
        exp_a.push_back(r * pw + c);
        exp_d.push_back((c < rw && (r * rw + c) < ndata) ? dat[r * rw + c] : 32'd0);
      end
    end
  endtask

  task automatic check_dut(input string tag, input int sel, input logic [2:0] onehot, input int dn_before);
    logic [63:0] got[$];
    logic [63:0] expq[$];
    logic        ovf;
    int          aw;
    aw  = (sel == 0) ? 11 : 4;
    ovf = 1'b0;
    if (sel == 0) got = q0; else got = q4;
    foreach (exp_a[i]) begin
      if (exp_a[i] < (1 << aw)) expq.push_back(pk(onehot, 16'(exp_a[i]), exp_d[i]));
      else ovf = 1'b1;
    end
    chk($sformatf("%s_a%0d_nwr", tag, aw), got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      chk($sformatf("%s_a%0d_wr%0d", tag, aw, i), got[i], expq[i]);
    chk($sformatf("%s_a%0d_err", tag, aw), (sel == 0) ? err0 : err4, {ovf, exp_long, exp_short});
    chk($sformatf("%s_a%0d_done", tag, aw), ((sel == 0) ? dn0 : dn4) - dn_before, 1);
    chk($sformatf("%s_a%0d_busy", tag, aw), (sel == 0) ? busy0 : busy4, 0);
  endtask

  // Called and returns on a negedge; beat i is offered until handshaken.
  task automatic drive(input string tag, input int n, input int tl, input bit gaps, output int cyc);
    int i;
    bit hs;
    i   = 0;
    cyc = 0;
    while (i < n && cyc < 2000) begin
      tvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      tdata  = dat[i];
      tlast  = (i + 1 == tl);
      hs     = tvalid && tready0;
      @(negedge clk);
      cyc++;
      if (hs) i++;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    if (i < n) chk({tag, "_stall"}, i, n);
  endtask

  task automatic start_cfg(input int bank, input int rw, input int rows, input logic [2:0] mask);
    @(negedge clk);
    cfg_bank  = 2'(bank);
    cfg_rw    = 16'(rw);
    cfg_rows  = 16'(rows);
    cfg_mask  = mask;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic run_load(input string tag, input int bank, input int rw, input int rows,
                          input logic [2:0] mask, input int tl, input bit gaps, input bit nostall);
    int b0, b4, cyc, w;
    dat.delete();
    for (int i = 0; i < tl; i++) dat.push_back($urandom);
    q0.delete();
    q4.delete();
    b0 = dn0;
    b4 = dn4;
    start_cfg(bank, rw, rows, mask);
    drive(tag, tl, tl, gaps, cyc);
    if (nostall) chk({tag, "_cycles"}, cyc, tl);
    w = 0;
    while (dn0 == b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    model(rw, rows, mask[bank], tl);
    check_dut(tag, 0, 3'(1 << bank), b0);
    check_dut(tag, 1, 3'(1 << bank), b4);
  endtask

  initial begin
    int bank, rw, rows, total, tl, cyc, b0;
    logic [2:0] mask;
    rst = 1'b1; tdata = '0; tvalid = 1'b0; tlast = 1'b0; cfg_start = 1'b0;
    cfg_bank = '0; cfg_rw = '0; cfg_rows = '0; cfg_mask = '0;
    repeat (3) @(negedge clk);
    chk("reset_out_a11", {tready0, we0, addr0, din0, busy0, done0, err0}, 0);
    chk("reset_out_a4",  {tready4, we4, addr4, din4, busy4, done4, err4}, 0);
    rst = 1'b0;
    @(negedge clk);

    run_load("padded",   0, 5, 2, 3'b001, 10, 1'b1, 1'b0);
    run_load("unpadded", 1, 6, 1, 3'b101, 6,  1'b0, 1'b1);
    run_load("early",    2, 4, 3, 3'b111, 6,  1'b1, 1'b0);
    run_load("missing",  0, 4, 1, 3'b000, 7,  1'b0, 1'b1);
    run_load("overflow", 1, 8, 3, 3'b000, 24, 1'b0, 1'b1);
    run_load("zero_rw",  0, 0, 3, 3'b111, 0,  1'b0, 1'b0);
    run_load("zero_rows", 2, 3, 0, 3'b111, 0, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      bank  = $urandom_range(0, 2);
      rw    = $urandom_range(1, 9);
      rows  = $urandom_range(1, 4);
      mask  = 3'($urandom_range(0, 7));
      total = rw * rows;
      tl    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, total + 3) : total;
      run_load($sformatf("rand%0d", k), bank, rw, rows, mask, tl, 1'b1, 1'b0);
    end

    // Abort a load after three beats, then check a clean reload.
    dat.delete();
    for (int i = 0; i < 3; i++) dat.push_back($urandom);
    q0.delete();
    q4.delete();
    b0 = dn0;
    start_cfg(0, 4, 2, 3'b000);
    drive("midrst", 3, 0, 1'b0, cyc);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_a11", {tready0, we0, addr0, din0, busy0, done0, err0}, 0);
    chk("midrst_out_a4",  {tready4, we4, addr4, din4, busy4, done4, err4}, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst_nwr", q0.size(), 3);
    chk("midrst_nodone", dn0 - b0, 0);
    run_load("after_rst", 0, 4, 2, 3'b000, 8, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
